uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_pick.sv | 36 +++
 rtl/uart_tx_arb.sv | 131 +++++++++++++
 tb/tb_uart_tx_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and default sizing for the UART TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int C_N_REQ      = 4;
    localparam int C_DATA_WIDTH = 8;
    localparam int C_MAX_LEN    = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; searches ptr+1 upward with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = C_N_REQ,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    logic [PTR_W-1:0] w_idx;

    // The current pointer owner is visited last, so it has lowest priority.
    always_comb begin
        grant = '0;
        w_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = PTR_W'((int'(ptr) + k) % N_REQ);
            if (req[w_idx] && (grant == '0)) begin
                grant[w_idx] = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin arbiter granting whole messages onto a uart_tx FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ      = C_N_REQ,
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int MAX_LEN    = C_MAX_LEN
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [N_REQ-1:0]                 req_valid_i,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_data_i,
    input  logic [N_REQ-1:0]                 req_last_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    input  logic                             tx_full_i,
    output logic                             tx_we_o,
    output logic [DATA_WIDTH-1:0]            din_o,
    output logic [N_REQ-1:0]                 grant_o,
    output logic                             busy_o,
    output logic                             preempt_o
);

    localparam int                 C_PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]         C_CNT_LIMIT = 8'(MAX_LEN - 1);
    localparam logic [C_PTR_W-1:0] C_PTR_RST   = C_PTR_W'(N_REQ - 1);

    arb_state_e              r_state,   w_state_nxt;
    logic [N_REQ-1:0]        r_grant,   w_grant_nxt;
    logic [C_PTR_W-1:0]      r_ptr,     w_ptr_nxt;
    logic [7:0]              r_cnt,     w_cnt_nxt;
    logic                    r_preempt, w_preempt_nxt;

    logic [N_REQ-1:0]        w_pick_grant;
    logic                    w_pick_valid;
    logic [C_PTR_W-1:0]      w_owner_idx;
    logic [DATA_WIDTH-1:0]   w_owner_data;
    logic                    w_owner_valid;
    logic                    w_owner_last;
    logic                    w_xfer;
    logic                    w_accept;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (C_PTR_W)
    ) u_rr_pick (
        .req   (req_valid_i),
        .ptr   (r_ptr),
        .grant (w_pick_grant),
        .valid (w_pick_valid)
    );

    // Owner selection is driven only by the registered grant, so non-owner inputs never leak.
    always_comb begin
        w_owner_idx  = '0;
        w_owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_owner_idx  = C_PTR_W'(i);
                w_owner_data = req_data_i[i];
            end
        end
    end

    assign w_owner_valid = |(req_valid_i & r_grant);
    assign w_owner_last  = |(req_last_i & r_grant);
    assign w_xfer        = (r_state == XFER);
    assign w_accept      = w_xfer && w_owner_valid && !tx_full_i;

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_preempt_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = XFER;
                    w_grant_nxt = w_pick_grant;
                    w_cnt_nxt   = '0;
                end
            end
            XFER: begin
                if (w_accept) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    // A last byte ends the message normally even when it also hits the limit.
                    if (w_owner_last || (r_cnt == C_CNT_LIMIT)) begin
                        w_state_nxt   = IDLE;
                        w_grant_nxt   = '0;
                        w_ptr_nxt     = w_owner_idx;
                        w_preempt_nxt = !w_owner_last;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_ptr     <= C_PTR_RST;
            r_cnt     <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_preempt <= w_preempt_nxt;
        end
    end

    assign tx_we_o     = w_accept && !rst_i;
    assign din_o       = tx_we_o ? w_owner_data : '0;
    assign req_ready_o = (w_xfer && !tx_full_i && !rst_i) ? r_grant : '0;
    assign busy_o      = w_xfer && !rst_i;
    assign grant_o     = r_grant;
    assign preempt_o   = r_preempt;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Self-checking bench: vector table plus scoreboarded message sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    logic            clk;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0][7:0] req_data;
    logic [3:0]      req_last;
    logic [3:0]      req_ready;
    logic            tx_full;
    logic            tx_we;
    logic [7:0]      din;
    logic [3:0]      grant;
    logic            busy;
    logic            preempt;

    uart_tx_arb #(
        .N_REQ      (4),
        .DATA_WIDTH (8),
        .MAX_LEN    (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_full_i   (tx_full),
        .tx_we_o     (tx_we),
        .din_o       (din),
        .grant_o     (grant),
        .busy_o      (busy),
        .preempt_o   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic        we;
        logic [7:0]  din;
        logic        busy;
        logic [3:0]  grant;
        logic [3:0]  ready;
    } vec_t;

    int          n_pass;
    int          n_total;
    int          preempt_seen;
    logic [11:0] sb[$];
    logic [7:0]  mem[4][8];
    int          len[4];
    int          pos[4];
    logic        pend;
    int          pend_idx;
    vec_t        tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                                input logic [3:0] l, input logic f, input logic w,
                                input logic [7:0] dn, input logic b, input logic [3:0] g,
                                input logic [3:0] rd);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.last = l; t.full = f;
        t.we = w; t.din = dn; t.busy = b; t.grant = g; t.ready = rd;
        return t;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            if (pos[i] < len[i]) begin
                req_valid[i] = 1'b1;
                req_data[i]  = mem[i][pos[i]];
                req_last[i]  = (pos[i] == len[i] - 1);
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = 8'h00;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic load(input int i, input int n, input logic [7:0] base);
        len[i] = n;
        pos[i] = 0;
        for (int k = 0; k < n; k++) mem[i][k] = base + 8'(k);
    endtask

    task automatic push(input logic [3:0] g, input logic [7:0] b);
        sb.push_back({g, b});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_full = 1'b0;
        pend = 1'b0;
        preempt_seen = 0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            len[i] = 0;
            pos[i] = 0;
        end
        drive_reqs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock of the requester model: apply last cycle's handshake, drive, then sample.
    task automatic cycle(input logic f, input logic r);
        logic [11:0] e;
        @(posedge clk);
        #1;
        if (pend) pos[pend_idx]++;
        pend = 1'b0;
        tx_full = f;
        rst = r;
        drive_reqs();
        #3;
        if (preempt) preempt_seen++;
        if (tx_we) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL sb_unexpected: got write din=%0h grant=%0h expected no write", din, grant);
            end else begin
                e = sb.pop_front();
                chk("sb_grant", 32'(grant), 32'(e[11:8]));
                chk("sb_din", 32'(din), 32'(e[7:0]));
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                pend = 1'b1;
                pend_idx = i;
            end
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (sb.size() > 0 && k < budget) begin
            cycle(1'b0, 1'b0);
            k++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        req_valid = '0;
        req_data = '0;
        req_last = '0;
        do_reset();

        // rst, valid, data, last, full | we, din, busy, grant, ready
        tbl[0]  = mk(1, 4'h0, 32'h00000000, 4'h0, 0, 0, 8'h00, 0, 4'h0, 4'h0);
        tbl[1]  = mk(0, 4'h4, 32'h00410000, 4'h0, 0, 0, 8'h00, 0, 4'h0, 4'h0);
        tbl[2]  = mk(0, 4'h4, 32'h00410000, 4'h0, 0, 1, 8'h41, 1, 4'h4, 4'h4);
        tbl[3]  = mk(0, 4'h4, 32'h00420000, 4'h0, 0, 1, 8'h42, 1, 4'h4, 4'h4);
        tbl[4]  = mk(0, 4'h4, 32'h00430000, 4'h4, 0, 1, 8'h43, 1, 4'h4, 4'h4);
        tbl[5]  = mk(0, 4'h0, 32'h00000000, 4'h0, 0, 0, 8'h00, 0, 4'h0, 4'h0);
        tbl[6]  = mk(0, 4'hC, 32'h55000000, 4'h8, 0, 0, 8'h00, 0, 4'h0, 4'h0);
        tbl[7]  = mk(0, 4'hC, 32'h55000000, 4'h8, 0, 1, 8'h55, 1, 4'h8, 4'h8);
        tbl[8]  = mk(0, 4'h0, 32'h00000000, 4'h0, 0, 0, 8'h00, 0, 4'h0, 4'h0);
        tbl[9]  = mk(0, 4'h5, 32'h00220011, 4'h5, 0, 0, 8'h00, 0, 4'h0, 4'h0);
        tbl[10] = mk(0, 4'h5, 32'h00220011, 4'h5, 0, 1, 8'h11, 1, 4'h1, 4'h1);
        tbl[11] = mk(0, 4'h4, 32'h00220000, 4'h4, 0, 0, 8'h00, 0, 4'h0, 4'h0);
        tbl[12] = mk(0, 4'h4, 32'h00220000, 4'h4, 0, 1, 8'h22, 1, 4'h4, 4'h4);
        tbl[13] = mk(0, 4'h0, 32'h00000000, 4'h0, 0, 0, 8'h00, 0, 4'h0, 4'h0);
        tbl[14] = mk(0, 4'h2, 32'h00003300, 4'h2, 0, 0, 8'h00, 0, 4'h0, 4'h0);
        tbl[15] = mk(0, 4'h2, 32'h00003300, 4'h2, 1, 0, 8'h00, 1, 4'h2, 4'h0);
        tbl[16] = mk(0, 4'h2, 32'h00003300, 4'h2, 0, 1, 8'h33, 1, 4'h2, 4'h2);
        tbl[17] = mk(0, 4'h0, 32'h00000000, 4'h0, 0, 0, 8'h00, 0, 4'h0, 4'h0);

        for (int r = 0; r < 18; r++) begin
            rst = tbl[r].rst;
            req_valid = tbl[r].valid;
            req_data = tbl[r].data;
            req_last = tbl[r].last;
            tx_full = tbl[r].full;
            #3;
            chk($sformatf("tbl%0d_we", r), 32'(tx_we), 32'(tbl[r].we));
            chk($sformatf("tbl%0d_din", r), 32'(din), 32'(tbl[r].din));
            chk($sformatf("tbl%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
            chk($sformatf("tbl%0d_grant", r), 32'(grant), 32'(tbl[r].grant));
            chk($sformatf("tbl%0d_ready", r), 32'(req_ready), 32'(tbl[r].ready));
            @(posedge clk);
            #1;
        end

        // Round robin from reset: grants 0,1,2,3 separated by one idle bubble each.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load(i, 1, 8'hA0 + 8'(i));
            push(4'(1 << i), 8'hA0 + 8'(i));
        end
        for (int c = 0; c < 8; c++) begin
            cycle(1'b0, 1'b0);
            chk($sformatf("rr%0d_busy", c), 32'(busy), 32'(c % 2));
            chk($sformatf("rr%0d_grant", c), 32'(grant), (c % 2 == 1) ? (32'd1 << (c / 2)) : 32'd0);
        end
        drain(20);

        // Backpressure mid-message; last coincides with the length limit.
        do_reset();
        load(1, 4, 8'h61);
        for (int k = 0; k < 4; k++) push(4'h2, 8'h61 + 8'(k));
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0);
            chk($sformatf("bp%0d_we", k), 32'(tx_we), 32'd0);
            chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("bp%0d_din", k), 32'(din), 32'd0);
            chk($sformatf("bp%0d_grant", k), 32'(grant), 32'h2);
        end
        drain(20);
        chk("bp_no_preempt", 32'(preempt_seen), 32'd0);

        // Length limit: req 1 preempted after 4 bytes, req 3 served, req 1 resumes.
        do_reset();
        load(1, 6, 8'hB1);
        load(3, 1, 8'hC3);
        for (int k = 0; k < 4; k++) push(4'h2, 8'hB1 + 8'(k));
        push(4'h8, 8'hC3);
        push(4'h2, 8'hB5);
        push(4'h2, 8'hB6);
        drain(40);
        chk("maxlen_preempt_pulses", 32'(preempt_seen), 32'd1);

        // Reset mid-message, then requester 0 wins a simultaneous request.
        do_reset();
        load(2, 5, 8'hD1);
        push(4'h4, 8'hD1);
        push(4'h4, 8'hD2);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        chk("rstmid_we", 32'(tx_we), 32'd0);
        chk("rstmid_din", 32'(din), 32'd0);
        chk("rstmid_ready", 32'(req_ready), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        cycle(1'b0, 1'b1);
        chk("rstpost_grant", 32'(grant), 32'd0);
        chk("rstpost_busy", 32'(busy), 32'd0);
        chk("rstpost_sb", 32'(sb.size()), 32'd0);
        load(0, 1, 8'hE0);
        load(2, 1, 8'hE2);
        load(3, 1, 8'hE3);
        push(4'h1, 8'hE0);
        push(4'h4, 8'hE2);
        push(4'h8, 8'hE3);
        drain(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
